// File: rtl/sram_pkg.sv
// sram_pkg: controller state encoding and MMIO register indices shared by the SRAM controller slice.
package sram_pkg;
    typedef logic [2:0] state_t;
    localparam state_t IDLE   = 3'd0;
    localparam state_t SETUP  = 3'd1;
    localparam state_t ACCESS = 3'd2;
    localparam state_t HOLD   = 3'd3;
    localparam state_t MMIO   = 3'd4;
    localparam int STATUS    = 0;
    localparam int ADDRSTACK = 1;
    localparam int USERSTACK = 2;
    localparam int UART      = 3;
    localparam int GPIO      = 4;
    localparam int GPIODIR   = 5;
endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: CPU data-port request/ack bus between the CPU (master) and the SRAM controller (slave).
interface sram_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic                  req;
    logic                  write;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     dataIn;
    logic [DATA_W/8-1:0]   byte_en;
    logic                  ready;
    logic                  ack;
    logic [DATA_W-1:0]     dataOut;
    modport master (output req, write, address, dataIn, byte_en, input ready, ack, dataOut);
    modport slave  (input req, write, address, dataIn, byte_en, output ready, ack, dataOut);
endinterface

// File: rtl/sram_mmio_decode.sv
// sram_mmio_decode: flags addresses inside the MMIO window and produces the one-hot register select.
module sram_mmio_decode #(
    parameter int ADDR_W     = 16,
    parameter int MMIO_BASE  = 0,
    parameter int MMIO_COUNT = 6
) (
    input  logic [ADDR_W-1:0]     address,
    output logic                  in_window,
    output logic [MMIO_COUNT-1:0] sel
);
    localparam logic [ADDR_W:0] BASE = (ADDR_W+1)'(MMIO_BASE);
    localparam logic [ADDR_W:0] CNT  = (ADDR_W+1)'(MMIO_COUNT);
    logic [ADDR_W:0] off;
    // one extra bit so addresses below the base come out huge instead of wrapping into the window
    assign off       = {1'b0, address} - BASE;
    assign in_window = off < CNT;
    assign sel       = in_window ? MMIO_COUNT'(1) << off : '0;
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: handshaked async-SRAM controller with wait states, byte lanes and an MMIO window.
// Define SRAM_POSTED_WRITE_EN to acknowledge SRAM writes at acceptance instead of in HOLD.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 1,
    parameter int MMIO_BASE   = 0,
    parameter int MMIO_COUNT  = 6
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    sram_ctrl_if.slave            bus,
    output logic [MMIO_COUNT-1:0] mmio_sel,
    output logic                  mmio_write,
    output logic [DATA_W-1:0]     mmio_wdata,
    input  logic [DATA_W-1:0]     mmio_rdata,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [DATA_W-1:0]     sram_dq_in,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [DATA_W/8-1:0]   sram_be_n
);
    localparam int NB = DATA_W / 8;
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
`ifdef SRAM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [NB-1:0]       be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [MMIO_COUNT-1:0] sel_q, sel_d;
    logic                ack_q, ack_d;
    logic                hit, cyc_on;
    logic [MMIO_COUNT-1:0] hit_sel;
    sram_mmio_decode #(
        .ADDR_W(ADDR_W), .MMIO_BASE(MMIO_BASE), .MMIO_COUNT(MMIO_COUNT)
    ) u_decode (
        .address(bus.address), .in_window(hit), .sel(hit_sel)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        ack_d   = 1'b0;
        case (state_q)
            // the ack cycle of an MMIO access is already IDLE; a still-held req must not re-accept it
            IDLE: if (bus.req && !ack_q) begin
                state_d = hit ? MMIO : SETUP;
                wr_d    = bus.write;
                be_d    = bus.byte_en;
                wdata_d = bus.dataIn;
                sel_d   = hit_sel;
                addr_d  = hit ? addr_q : bus.address;
                ack_d   = POSTED && bus.write && !hit;
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = CW'(WAIT_STATES);
            end
            ACCESS: begin
                state_d = (cnt_q == '0) ? HOLD : ACCESS;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                dout_d  = (cnt_q == '0 && !wr_q) ? sram_dq_in : dout_q;
                ack_d   = (cnt_q == '0) && !(POSTED && wr_q);
            end
            HOLD: state_d = IDLE;
            MMIO: begin
                state_d = IDLE;
                ack_d   = 1'b1;
                dout_d  = wr_q ? dout_q : mmio_rdata;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            addr_q  <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
        end
    end
    assign cyc_on      = state_q inside {SETUP, ACCESS, HOLD};
    assign bus.ready   = (state_q == IDLE) && !ack_q;
    assign bus.ack     = ack_q;
    assign bus.dataOut = dout_q;
    assign mmio_sel    = (state_q == MMIO) ? sel_q : '0;
    assign mmio_write  = (state_q == MMIO) && wr_q;
    assign mmio_wdata  = wdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = wdata_q;
    assign sram_ce_n   = !cyc_on;
    assign sram_oe_n   = !(!wr_q && (state_q == SETUP || state_q == ACCESS));
    assign sram_we_n   = !(wr_q && state_q == ACCESS);
    // write data keeps driving through HOLD to cover the SRAM data hold time
    assign sram_dq_oe  = wr_q && cyc_on;
    assign sram_be_n   = cyc_on ? (wr_q ? ~be_q : '0) : '1;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench for sram_ctrl; the driver predicts each response from a memory/register
// model and a monitor compares it, with the cycle-level strobe counts, whenever the DUT acks.
module tb_sram_ctrl;
    import sram_pkg::*;
    localparam int WS = 1;
`ifdef SRAM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif
    typedef struct {
        bit          rd;
        bit          mm;
        bit          strobes;
        logic [15:0] data;
        int          lat;
        int          acc;
        logic [5:0]  sel;
        logic [1:0]  be_n;
    } exp_t;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [5:0]  mmio_sel;
    logic        mmio_write;
    logic [15:0] mmio_wdata, mmio_rdata;
    logic [15:0] sram_addr, sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [1:0]  sram_be_n;
    logic [15:0] mem [0:65535];
    logic [15:0] model_mem [0:65535];
    logic [15:0] mregs [0:5];
    logic [15:0] model_mmio [0:5];
    exp_t        sbq [$];
    int          checks = 0, errors = 0, cyc = 0, last_ack = 0;
    int          we_cnt = 0, ce_cnt = 0, oe_cnt = 0;
    logic [5:0]  sel_seen = '0;
    logic [1:0]  be_seen = '1;
    bit          held_prev = 0, prev_posted = 0;
    sram_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    sram_ctrl #(
        .ADDR_W(16), .DATA_W(16), .WAIT_STATES(WS), .MMIO_BASE(0), .MMIO_COUNT(6)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .bus(bus),
        .mmio_sel(mmio_sel), .mmio_write(mmio_write), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    // external async SRAM and MMIO register file seen through the pins
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;
    always @(posedge CLK) begin
        if (!sram_ce_n && !sram_we_n)
            for (int i = 0; i < 2; i++)
                if (!sram_be_n[i]) mem[sram_addr][8*i +: 8] = sram_dq_out[8*i +: 8];
        if (mmio_write)
            for (int i = 0; i < 6; i++)
                if (mmio_sel[i]) mregs[i] = mmio_wdata;
    end
    always_comb begin
        mmio_rdata = 16'h0000;
        for (int i = 0; i < 6; i++)
            if (mmio_sel[i]) mmio_rdata = mregs[i];
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            we_cnt = 0; ce_cnt = 0; oe_cnt = 0; sel_seen = '0; be_seen = '1;
        end else begin
            if (!sram_we_n) begin
                we_cnt++;
                be_seen = sram_be_n;
            end
            if (!sram_ce_n) ce_cnt++;
            if (sram_dq_oe) oe_cnt++;
            sel_seen |= mmio_sel;
            if (bus.ack) begin
                if (sbq.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    if (e.rd) check("rdata", bus.dataOut, e.data);
                    check("latency", cyc - e.acc, e.lat);
                    check("mmio_sel", sel_seen, e.sel);
                    if (e.strobes) begin
                        check("ce_cycles", ce_cnt, e.mm ? 0 : WS + 3);
                        check("we_cycles", we_cnt, (e.rd || e.mm) ? 0 : WS + 1);
                        check("dq_oe_cycles", oe_cnt, (e.rd || e.mm) ? 0 : WS + 3);
                        if (!e.rd && !e.mm) check("be_n", be_seen, e.be_n);
                    end
                end
                we_cnt = 0; ce_cnt = 0; oe_cnt = 0; sel_seen = '0; be_seen = '1;
            end
        end
    end
    // caller is positioned just after a posedge; returns just after the posedge following the ack
    task automatic run_txn(input bit wr, input logic [15:0] a, input logic [15:0] d,
                           input logic [1:0] be, input bit keep_req);
        exp_t e;
        int n;
        bus.req = 1'b1; bus.write = wr; bus.address = a; bus.dataIn = d; bus.byte_en = be;
        n = 0;
        @(negedge CLK);
        while (!bus.ready && n < 50) begin
            n++;
            @(negedge CLK);
        end
        if (!bus.ready) begin
            check("accept_timeout", 0, 1);
            bus.req = 1'b0;
            return;
        end
        e.rd = !wr; e.mm = a < 16'd6; e.acc = cyc; e.strobes = !POSTED;
        e.data = 16'h0; e.be_n = ~be; e.sel = '0;
        if (held_prev && !prev_posted) check("b2b_gap", e.acc - last_ack, 1);
        if (e.mm) begin
            e.sel = 6'd1 << a[2:0];
            e.lat = 2;
            if (wr) model_mmio[a[2:0]] = d;
            else e.data = model_mmio[a[2:0]];
        end else begin
            e.lat = (wr && POSTED) ? 1 : 3 + WS;
            if (wr) begin
                for (int i = 0; i < 2; i++)
                    if (be[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
            end else e.data = model_mem[a];
        end
        sbq.push_back(e);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!bus.ack && n < 50);
        if (!bus.ack) check("ack_timeout", 0, 1);
        last_ack = cyc;
        held_prev = keep_req;
        prev_posted = POSTED && wr && !e.mm;
        @(posedge CLK);
        #1;
        if (!keep_req) bus.req = 1'b0;
    endtask
    initial begin
        int n, acks;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'($urandom);
            model_mem[i] = mem[i];
        end
        for (int i = 0; i < 6; i++) begin
            mregs[i] = 16'($urandom);
            model_mmio[i] = mregs[i];
        end
        mem[16'h1234] = 16'hBEEF; model_mem[16'h1234] = 16'hBEEF;
        mregs[UART] = 16'h0041;   model_mmio[UART] = 16'h0041;
        bus.req = 1'b0; bus.write = 1'b0; bus.address = '0; bus.dataIn = '0; bus.byte_en = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ack", bus.ack, 0);
        check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe}, 6'b111110);
        check("rst_dataout", bus.dataOut, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_mmio", {mmio_sel, mmio_write}, 0);
        @(posedge CLK); #1 RST_N = 1'b1;
        @(negedge CLK);
        check("rst_ready", bus.ready, 1);
        @(posedge CLK); #1;
        run_txn(0, 16'h1234, 16'h0, 2'b00, 0);
        run_txn(1, 16'h0100, 16'hA55A, 2'b01, 0);
        check("lane_write", mem[16'h0100][7:0], 8'h5A);
        run_txn(0, 16'h0100, 16'h0, 2'b00, 0);
        run_txn(0, 16'(UART), 16'h0, 2'b00, 0);
        run_txn(1, 16'h0101, 16'h1357, 2'b00, 0);
        run_txn(0, 16'h0101, 16'h0, 2'b00, 0);
        run_txn(0, 16'h0006, 16'h0, 2'b00, 0);
        run_txn(1, 16'(GPIO), 16'h00F0, 2'b11, 0);
        run_txn(0, 16'(GPIO), 16'h0, 2'b00, 0);
        run_txn(0, 16'h0102, 16'h0, 2'b00, 1);
        run_txn(0, 16'h0103, 16'h0, 2'b00, 1);
        run_txn(0, 16'h0104, 16'h0, 2'b00, 0);
        // reset in the middle of a write: strobes must drop and no ack may follow
        bus.req = 1'b1; bus.write = 1'b1; bus.address = 16'h8000; bus.dataIn = 16'h1111; bus.byte_en = 2'b11;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (sram_we_n && n < 20);
        check("abort_in_access", sram_we_n, 0);
        bus.req = 1'b0;
        RST_N = 1'b0;
        @(negedge CLK);
        check("abort_strobes", {sram_we_n, sram_dq_oe, sram_ce_n, bus.ack}, 4'b1010);
        @(posedge CLK); #1 RST_N = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge CLK);
            acks += int'(bus.ack);
        end
        check("abort_no_ack", acks, 0);
        held_prev = 0;
        @(posedge CLK); #1;
        run_txn(0, 16'h0100, 16'h0, 2'b00, 0);
        for (int k = 0; k < 60; k++) begin
            a = ($urandom_range(0, 9) < 2) ? 16'($urandom_range(0, 5)) : 16'h0100 + 16'($urandom_range(0, 15));
            run_txn(1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)),
                    (k != 59) && ($urandom_range(0, 1) == 1));
            if (!bus.req) repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
        end
        repeat (8) @(negedge CLK);
        check("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
